// File: rtl/tlb_stage_pkg.sv
// Shared definitions for the address-translation stage: TLB geometry,
// ldSt_enable encodings and the page-walk FSM states.
package tlb_stage_pkg;

    localparam int unsigned ENTRIES = 4;
    localparam int unsigned VPN_W   = 8;

    localparam logic [1:0] LDST_NONE  = 2'b00;
    localparam logic [1:0] LDST_LOAD  = 2'b01;
    localparam logic [1:0] LDST_STORE = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WALK = 1'b1
    } walk_state_e;

endpackage

// File: rtl/register.sv
// Generic pipeline register with synchronous active-high reset and load enable.
module register #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (enable) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/tlb_stage_cam.sv
// Fully-associative TLB array: parallel VPN match, round-robin refill,
// and a flush that clears all valid bits while leaving the pointer alone.
module tlb_cam #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned VPN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic [VPN_W-1:0] lookup_vpn_i,
    output logic             hit_o,
    output logic [VPN_W-1:0] ppn_o,
    input  logic             fill_i,
    input  logic [VPN_W-1:0] fill_vpn_i,
    input  logic [VPN_W-1:0] fill_ppn_i
);

    localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   ppn_q [ENTRIES];
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;

    assign ptr_d = ptr_q + PTR_W'(1);

    // Only misses fill, so at most one entry matches and OR-merging is safe.
    always_comb begin
        hit_o = 1'b0;
        ppn_o = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (vpn_q[i] == lookup_vpn_i)) begin
                hit_o = 1'b1;
                ppn_o = ppn_o | ppn_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            ptr_q   <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (fill_i) begin
            valid_q[ptr_q] <= 1'b1;
            ptr_q          <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush_i && fill_i) begin
            vpn_q[ptr_q] <= fill_vpn_i;
            ppn_q[ptr_q] <= fill_ppn_i;
        end
    end

endmodule

// File: rtl/tlb_stage.sv
// Address-translation stage between ALU and cache_stage: TLB lookup for
// loads/stores, miss stall with page-walk refill, 40-bit output register.
module tlb_stage #(
    parameter int unsigned ENTRIES = tlb_stage_pkg::ENTRIES,
    parameter int unsigned VPN_W   = tlb_stage_pkg::VPN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_tlb,
    input  logic [15:0]      alu_result,
    input  logic [2:0]       destReg_addr_input,
    input  logic             we_input,
    input  logic [1:0]       bp_input,
    input  logic [15:0]      dataReg,
    input  logic [1:0]       ldSt_enable,
    input  logic             tlb_flush,
    output logic             walk_req,
    output logic [VPN_W-1:0] walk_vpn,
    input  logic             walk_valid,
    input  logic [VPN_W-1:0] walk_ppn,
    output logic             stall_tlb,
    output logic [15:0]      tlb_result,
    output logic [2:0]       destReg_addr_output,
    output logic             we_output,
    output logic [1:0]       bp_output,
    output logic [15:0]      dataReg_output,
    output logic [1:0]       ldSt_enable_output
);

    import tlb_stage_pkg::*;

    localparam int unsigned OFF_W = 16 - VPN_W;

    walk_state_e      state_q;
    logic             walk_req_q;
    logic [VPN_W-1:0] walk_vpn_q;

    logic             is_mem;
    logic [VPN_W-1:0] vpn;
    logic             cam_hit;
    logic [VPN_W-1:0] cam_ppn;
    logic             miss;
    logic             fill;
    logic [15:0]      result_d;
    logic [39:0]      pipe_d;
    logic [39:0]      pipe_q;

    assign is_mem = (ldSt_enable == LDST_LOAD) || (ldSt_enable == LDST_STORE);
    assign vpn    = alu_result[15:OFF_W];
    assign miss   = is_mem && !cam_hit;
    assign fill   = (state_q == ST_WALK) && walk_valid;

    assign stall_tlb = miss;
    assign walk_req  = walk_req_q;
    assign walk_vpn  = walk_vpn_q;

    tlb_cam #(
        .ENTRIES (ENTRIES),
        .VPN_W   (VPN_W)
    ) u_cam (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (tlb_flush),
        .lookup_vpn_i (vpn),
        .hit_o        (cam_hit),
        .ppn_o        (cam_ppn),
        .fill_i       (fill),
        .fill_vpn_i   (walk_vpn_q),
        .fill_ppn_i   (walk_ppn)
    );

    // A flush coincident with walk_valid still returns to IDLE; the CAM drops the fill.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            walk_req_q <= 1'b0;
            walk_vpn_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (miss) begin
                        state_q    <= ST_WALK;
                        walk_req_q <= 1'b1;
                        walk_vpn_q <= vpn;
                    end
                end
                ST_WALK: begin
                    if (walk_valid) begin
                        state_q    <= ST_IDLE;
                        walk_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    walk_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign result_d = is_mem ? {cam_ppn, alu_result[OFF_W-1:0]} : alu_result;
    assign pipe_d   = miss ? '0 : {result_d, destReg_addr_input, we_input,
                                   bp_input, dataReg, ldSt_enable};

    register #(
        .WIDTH (40)
    ) u_pipe_reg (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable_tlb),
        .data_in  (pipe_d),
        .data_out (pipe_q)
    );

    assign {tlb_result, destReg_addr_output, we_output,
            bp_output, dataReg_output, ldSt_enable_output} = pipe_q;

endmodule
